// File: rtl/note_scheduler.sv
// Song-step sequencer: walks the song ROM one step per beat and registers each note toward the delay line.
// Handles pause/resume, stop, and the drain period that flushes the delay line after the last note.
module note_scheduler #(
  parameter int SONG_LEN    = 64,
  parameter int ADDR_W      = 6,
  parameter int TEMPO_DIV   = 4,
  parameter int DRAIN_STEPS = 18
) (
  input  logic              clk_slow,
  input  logic              rst,
  input  logic              start,
  input  logic              pause,
  input  logic              stop,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [4:0]        rom_data,
  output logic [4:0]        note_out,
  output logic              busy,
  output logic              song_done,
  output logic [1:0]        state_o,
  output logic [7:0]        notes_emitted
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(SONG_LEN - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE   = ADDR_W'(1);
  localparam logic [3:0]        DIV_LAST   = 4'(TEMPO_DIV - 1);
  localparam logic [4:0]        DRAIN_LAST = 5'(DRAIN_STEPS - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        div_q, div_d;
  logic [4:0]        drain_q, drain_d;
  logic [4:0]        note_q, note_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  // State and counter registers, cleared asynchronously by rst.
  always_ff @(posedge clk_slow or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      div_q   <= 4'd0;
      drain_q <= 5'd0;
      note_q  <= 5'd0;
      cnt_q   <= 8'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      div_q   <= div_d;
      drain_q <= drain_d;
      note_q  <= note_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic; command priority is stop, then pause, then start.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    div_d   = div_q;
    drain_d = drain_q;
    note_d  = 5'd0;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        addr_d = '0;
        if (!stop && start) begin
          state_d = ST_PLAY;
          div_d   = 4'd0;
          cnt_d   = 8'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PLAY: begin
        if (stop) begin
          state_d = ST_IDLE;
          addr_d  = '0;
          div_d   = 4'd0;
        end else if (pause) begin
          // A beat due on this cycle stays pending; div_cnt stays 0 so resume emits it.
          state_d = ST_PAUSE;
        end else begin
          div_d = (div_q == DIV_LAST) ? 4'd0 : div_q + 4'd1;
          if (div_q == 4'd0) begin
            note_d = rom_data;
            if (rom_data != 5'd0 && cnt_q != 8'hFF) begin
              cnt_d = cnt_q + 8'd1;
            end else begin
              cnt_d = cnt_q;
            end
            if (addr_q == LAST_ADDR) begin
              state_d = ST_DRAIN;
              addr_d  = '0;
              drain_d = 5'd0;
            end else begin
              addr_d = addr_q + ADDR_ONE;
            end
          end else begin
            note_d = 5'd0;
          end
        end
      end
      ST_PAUSE: begin
        if (stop) begin
          state_d = ST_IDLE;
          addr_d  = '0;
          div_d   = 4'd0;
        end else if (pause || start) begin
          state_d = ST_PLAY;
        end else begin
          state_d = ST_PAUSE;
        end
      end
      ST_DRAIN: begin
        if (stop) begin
          state_d = ST_IDLE;
          addr_d  = '0;
          div_d   = 4'd0;
        end else if (drain_q == DRAIN_LAST) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          drain_d = drain_q + 5'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        addr_d  = '0;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  assign rom_addr      = addr_q;
  assign note_out      = note_q;
  assign busy          = busy_q;
  assign song_done     = done_q;
  assign state_o       = state_q;
  assign notes_emitted = cnt_q;

endmodule

// File: doc/note_scheduler.md
NOTE_SCHEDULER -- requirements
Module: note_scheduler

Interface
REQ-001 Parameter SONG_LEN, default 64: number of note steps in the song ROM (2..256).
REQ-002 Parameter ADDR_W, default 6: ROM address width, with 2^ADDR_W >= SONG_LEN.
REQ-003 Parameter TEMPO_DIV, default 4: clk_slow cycles per beat (1..16).
REQ-004 Parameter DRAIN_STEPS, default 18: cycles needed to flush the downstream 18-stage note delay line.
REQ-005 Port clk_slow, input, 1: game tick clock; all state changes on its rising edge.
REQ-006 Port rst, input, 1: reset, asynchronous, active-low.
REQ-007 Port start, input, 1: single-cycle command to begin, or to resume from PAUSE.
REQ-008 Port pause, input, 1: single-cycle command that toggles between PLAY and PAUSE.
REQ-009 Port stop, input, 1: single-cycle command to abort to IDLE.
REQ-010 Port rom_addr, output, ADDR_W: song ROM address, equal to the internal step pointer.
REQ-011 Port rom_data, input, 5: note pattern, combinationally valid for rom_addr in the same cycle.
REQ-012 Port note_out, output, 5: registered note fed to the delay-line input each clk_slow.
REQ-013 Port busy, output, 1: high in PLAY, PAUSE and DRAIN.
REQ-014 Port song_done, output, 1: one-cycle pulse on normal song completion.
REQ-015 Port state_o, output, 2: state encoding IDLE=0, PLAY=1, PAUSE=2, DRAIN=3.
REQ-016 Port notes_emitted, output, 8: count of nonzero notes emitted this song, saturating at 255.

Function
REQ-017 Registered counters SHALL be addr (ADDR_W bits), div_cnt (4 bits) and drain_cnt (5 bits).
REQ-018 IDLE SHALL hold note_out=0 and addr=0.
- On start, the next state SHALL be PLAY with div_cnt=0 and notes_emitted=0.
REQ-019 PLAY with div_cnt==0 (beat tick) SHALL register note_out<=rom_data and increment addr.
- When rom_data!=0, notes_emitted SHALL increment, saturating at 255.
REQ-020 PLAY with div_cnt!=0 SHALL register note_out<=0.
REQ-021 In PLAY, div_cnt SHALL count 0..TEMPO_DIV-1 and wrap to 0.
- With TEMPO_DIV=1, every PLAY cycle SHALL be a beat tick.
REQ-022 The beat tick at addr==SONG_LEN-1 SHALL emit that note and enter DRAIN.
- On that edge: drain_cnt=0, addr=0, no wrap into replay.
REQ-023 DRAIN SHALL output note_out=0 and increment drain_cnt every cycle.
- At drain_cnt==DRAIN_STEPS-1: enter IDLE and assert song_done for exactly the next cycle.
- DRAIN therefore lasts exactly DRAIN_STEPS cycles.
REQ-024 PAUSE SHALL output note_out=0 and freeze addr, div_cnt and notes_emitted.
- pause or start SHALL return the FSM to PLAY with its counters unchanged.
REQ-025 Command priority SHALL be stop > pause > start.
REQ-026 stop in any non-IDLE state SHALL enter IDLE next cycle.
- On that edge: addr=0, note_out=0, div_cnt=0.
- song_done SHALL NOT assert on stop.
REQ-027 pause on the same cycle as a beat tick SHALL win.
- The note is not emitted and addr is not advanced.
- After resume, the first PLAY cycle SHALL emit that note.
REQ-028 pause on the final beat tick SHALL enter PAUSE, not DRAIN.
REQ-029 start in PLAY or DRAIN SHALL be ignored.
- pause in IDLE or DRAIN SHALL be ignored.
REQ-030 busy SHALL be a registered decode of the state (1 in PLAY, PAUSE and DRAIN).
- state_o SHALL equal the state register.

Reset
REQ-031 While rst=0, the block SHALL hold: state=IDLE, addr=0, div_cnt=0, drain_cnt=0, note_out=0, busy=0, song_done=0, notes_emitted=0.
REQ-032 Asserting rst mid-song SHALL abandon the song immediately, with no song_done.
- After release, only start SHALL begin a new song.

Verification
(Scenarios 1-5 use SONG_LEN=4, TEMPO_DIV=2, DRAIN_STEPS=3, ROM={01,02,04,10}.)
REQ-033 Scenario 1, normal play:
- Stimulus: start pulse.
- note_out over consecutive cycles SHALL read 01,00,02,00,04,00,10.
- Then 00 for 3 DRAIN cycles; song_done SHALL be high for exactly 1 cycle.
- After that: busy=0 and notes_emitted=4.
REQ-034 Scenario 2, pause on a beat:
- Stimulus: pause on the cycle the 02 beat is due, then start 5 cycles later.
- note_out SHALL be 00 throughout PAUSE with rom_addr frozen at 1.
- The first cycle after resume SHALL emit 02.
REQ-035 Scenario 3, stop during DRAIN:
- Stimulus: stop on the second DRAIN cycle.
- Next cycle SHALL show state_o=0 and rom_addr=0.
- song_done SHALL never assert.
REQ-036 Scenario 4, simultaneous commands:
- Stimulus: stop and pause in the same PLAY cycle -> the FSM SHALL enter IDLE.
- Stimulus: pause and start in the same PLAY cycle -> the FSM SHALL enter PAUSE.
REQ-037 Scenario 5, zero notes:
- ROM={00,05,00,00}: notes_emitted SHALL end at 1.
- note_out SHALL carry 05 on the second beat only.
REQ-038 Scenario 6, reset mid-song:
- Setup: TEMPO_DIV=1.
- Stimulus: rst=0 during PLAY at addr 3.
- All outputs SHALL be zero immediately, asynchronously.
- A later start SHALL replay from ROM address 0.
